// File: rtl/mem_arbiter_if.sv
// Requester/memory bundle for the two-port memory arbiter.
// master drives requests and read data, slave is the arbiter.
interface mem_arbiter_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  req0;
  logic                  req1;
  logic [WORD_WIDTH-1:0] addr0;
  logic [WORD_WIDTH-1:0] addr1;
  logic                  wr_en0;
  logic                  wr_en1;
  logic [WORD_WIDTH-1:0] wdata0;
  logic [WORD_WIDTH-1:0] wdata1;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  gnt0;
  logic                  gnt1;
  logic [WORD_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic                  mem_wr_en;
  logic [WORD_WIDTH-1:0] rdata;
  logic                  timeout;
  logic                  viol;

  modport master (
    output req0, req1, addr0, addr1,
    output wr_en0, wr_en1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, mem_addr, mem_wdata,
    input  mem_wr_en, rdata, timeout, viol
  );

  modport slave (
    input  req0, req1, addr0, addr1,
    input  wr_en0, wr_en1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, mem_addr, mem_wdata,
    output mem_wr_en, rdata, timeout, viol
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester shared memory arbiter with round-robin ties,
// bounded hold under contention and a mandatory release gap.
module mem_arbiter #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_HOLD   = 64
) (
  input  logic          clock,
  input  logic          nreset,
  mem_arbiter_if.slave  bus
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e        state;
  state_e        state_nx;
  logic [CW-1:0] hold;
  logic          last_served;
  logic          timeout_q;
  logic          timeout_nx;
  logic          viol_q;
  logic          gnt0;
  logic          gnt1;
  logic          owning;
  logic          entering;
  logic          at_limit;

  assign gnt0     = (state == OWN0);
  assign gnt1     = (state == OWN1);
  assign owning   = gnt0 | gnt1;
  assign at_limit = (hold == HOLD_LAST);
  assign entering = (state == IDLE) &&
                    ((state_nx == OWN0) ||
                     (state_nx == OWN1));

  // next-state: arbitration in IDLE, release rules while owning
  always_comb begin
    state_nx   = state;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_served))
          state_nx = OWN0;
        else if (bus.req1)
          state_nx = OWN1;
      end
      OWN0: begin
        if (!bus.req0) begin
          state_nx = GAP;
        end else if (bus.req1 && at_limit) begin
          state_nx   = GAP;
          timeout_nx = 1'b1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_nx = GAP;
        end else if (bus.req0 && at_limit) begin
          state_nx   = GAP;
          timeout_nx = 1'b1;
        end
      end
      GAP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register, owner history and pulse outputs
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      timeout_q   <= 1'b0;
      viol_q      <= 1'b0;
    end else begin
      state     <= state_nx;
      timeout_q <= timeout_nx;
      viol_q    <= (gnt0 & bus.wr_en1) |
                   (gnt1 & bus.wr_en0);
      if (entering)
        last_served <= (state_nx == OWN1);
    end
  end

  // hold counter: clear on grant, count up, stick at the limit
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hold <= '0;
    end else if (entering) begin
      hold <= '0;
    end else if (owning && !at_limit) begin
      hold <= hold + CW'(1);
    end
  end

  // memory-side mux follows the current owner only
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wr_en = 1'b0;
    unique case (1'b1)
      gnt0: begin
        bus.mem_addr  = bus.addr0;
        bus.mem_wdata = bus.wdata0;
        bus.mem_wr_en = bus.wr_en0;
      end
      gnt1: begin
        bus.mem_addr  = bus.addr1;
        bus.mem_wdata = bus.wdata1;
        bus.mem_wr_en = bus.wr_en1;
      end
      default: ;
    endcase
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rdata   = bus.mem_rdata;
  assign bus.timeout = timeout_q;
  assign bus.viol    = viol_q;

  a_onehot: assert property (
    @(posedge clock) disable iff (!nreset)
    !(gnt0 && gnt1));

  a_wr_owned: assert property (
    @(posedge clock) disable iff (!nreset)
    bus.mem_wr_en |-> owning);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cycles push
// expected outputs, a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam logic [15:0] A0  = 16'h1200;
  localparam logic [15:0] D0  = 16'hA0A0;
  localparam logic [15:0] A1  = 16'h068A;
  localparam logic [15:0] D1  = 16'h0005;
  localparam logic [15:0] BA0 = 16'h4321;
  localparam logic [15:0] BD0 = 16'h8765;

  typedef struct {
    string       name;
    bit          tgt;
    logic [1:0]  gnt;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        to;
    logic        vi;
    bit          vcare;
    logic [15:0] rd;
  } exp_t;

  logic        clk;
  logic        nreset;
  logic [15:0] rd_pat;
  int          checks;
  int          errors;
  exp_t        q[$];

  mem_arbiter_if #(.WORD_WIDTH(16)) bus ();
  mem_arbiter_if #(.WORD_WIDTH(16)) bus_b ();

  mem_arbiter #(.WORD_WIDTH(16), .MAX_HOLD(4)) dut (
    .clock  (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  mem_arbiter #(.WORD_WIDTH(16), .MAX_HOLD(64)) dut_b (
    .clock  (clk),
    .nreset (nreset),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set(input logic r0, input logic r1,
                     input logic w0, input logic w1);
    bus.req0   = r0;
    bus.req1   = r1;
    bus.wr_en0 = w0;
    bus.wr_en1 = w1;
  endtask

  task automatic put(input string n, input bit t,
                     input logic [1:0] g, input logic w,
                     input logic [15:0] a,
                     input logic [15:0] d,
                     input logic to, input logic vi,
                     input bit vc);
    exp_t e;
    rd_pat          = rd_pat + 16'h1357;
    bus.mem_rdata   = rd_pat;
    bus_b.mem_rdata = ~rd_pat;
    e.name  = n;
    e.tgt   = t;
    e.gnt   = g;
    e.wr    = w;
    e.addr  = a;
    e.wdata = d;
    e.to    = to;
    e.vi    = vi;
    e.vcare = vc;
    e.rd    = t ? ~rd_pat : rd_pat;
    q.push_back(e);
  endtask

  // monitor: one expected record per cycle, checked mid-cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [1:0]  g;
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic        to;
    logic        vi;
    logic [15:0] rd;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.tgt) begin
        g  = {bus_b.gnt1, bus_b.gnt0};
        w  = bus_b.mem_wr_en;
        a  = bus_b.mem_addr;
        d  = bus_b.mem_wdata;
        to = bus_b.timeout;
        vi = bus_b.viol;
        rd = bus_b.rdata;
      end else begin
        g  = {bus.gnt1, bus.gnt0};
        w  = bus.mem_wr_en;
        a  = bus.mem_addr;
        d  = bus.mem_wdata;
        to = bus.timeout;
        vi = bus.viol;
        rd = bus.rdata;
      end
      checks++;
      if (g !== e.gnt || w !== e.wr || a !== e.addr ||
          d !== e.wdata || to !== e.to || rd !== e.rd ||
          (e.vcare && vi !== e.vi)) begin
        errors++;
        $display("FAIL %s: got gnt=%b wr=%b addr=%h wdata=%h to=%b viol=%b rdata=%h; want gnt=%b wr=%b addr=%h wdata=%h to=%b viol=%b rdata=%h",
                 e.name, g, w, a, d, to, vi, rd,
                 e.gnt, e.wr, e.addr, e.wdata, e.to, e.vi, e.rd);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rd_pat = 16'h0;
    nreset = 1'b0;
    set(0, 0, 0, 0);
    bus.addr0  = A0;
    bus.wdata0 = D0;
    bus.addr1  = A1;
    bus.wdata1 = D1;
    bus.mem_rdata = '0;
    bus_b.req0 = 1'b0;
    bus_b.req1 = 1'b0;
    bus_b.wr_en0 = 1'b0;
    bus_b.wr_en1 = 1'b0;
    bus_b.addr0  = BA0;
    bus_b.wdata0 = BD0;
    bus_b.addr1  = 16'h0F0F;
    bus_b.wdata1 = 16'h3C3C;
    bus_b.mem_rdata = '0;

    tick();
    put("reset", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    nreset = 1'b1;
    set(1, 1, 0, 0);
    put("idle_lat", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    put("tie_gnt0", 0, 2'b01, 0, A0, D0, 0, 0, 1);
    tick();
    set(0, 1, 0, 0);
    put("drop_req0", 0, 2'b01, 0, A0, D0, 0, 0, 1);
    tick();
    put("gap", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    put("idle_after_gap", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    set(0, 1, 0, 1);
    put("wr1_pass", 0, 2'b10, 1, A1, D1, 0, 0, 1);
    tick();
    put("wr1_hold", 0, 2'b10, 1, A1, D1, 0, 0, 1);
    tick();
    set(0, 0, 0, 1);
    put("wr1_last", 0, 2'b10, 1, A1, D1, 0, 0, 1);
    tick();
    set(0, 0, 1, 1);
    put("gap_no_wr", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    put("idle_no_wr", 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    set(1, 0, 0, 0);
    put("req0_lat", 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    set(1, 0, 0, 1);
    put("own0_wr1", 0, 2'b01, 0, A0, D0, 0, 0, 1);
    tick();
    set(1, 0, 1, 0);
    put("viol_pulse", 0, 2'b01, 1, A0, D0, 0, 1, 1);
    tick();
    set(0, 0, 0, 0);
    put("viol_clear", 0, 2'b01, 0, A0, D0, 0, 0, 1);
    tick();
    put("gap2", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    set(1, 0, 0, 0);
    put("idle2", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    set(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      put($sformatf("hold_c%0d", i), 0, 2'b01, 0, A0, D0,
          0, 0, 1);
      tick();
    end
    put("timeout", 0, 2'b00, 0, 0, 0, 1, 0, 1);
    tick();
    put("idle_tie", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    put("gnt1_after", 0, 2'b10, 0, A1, D1, 0, 0, 1);
    tick();
    set(1, 1, 0, 1);
    put("own1_wr", 0, 2'b10, 1, A1, D1, 0, 0, 1);
    tick();
    nreset = 1'b0;
    put("async_rst", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    nreset = 1'b1;
    set(1, 1, 0, 0);
    put("rst_idle", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    set(0, 0, 0, 0);
    put("tie_after_rst", 0, 2'b01, 0, A0, D0, 0, 0, 1);
    tick();
    put("gap3", 0, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();

    bus_b.req0 = 1'b1;
    put("b_idle", 1, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 200; i++) begin
      put("b_hold", 1, 2'b01, 0, BA0, BD0, 0, 0, 1);
      tick();
    end
    bus_b.req0 = 1'b0;
    put("b_last", 1, 2'b01, 0, BA0, BD0, 0, 0, 1);
    tick();
    put("b_gap", 1, 2'b00, 0, 0, 0, 0, 0, 1);
    tick();
    tick();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_WIDTH, default 16, SHALL set the width of addresses and data words.
REQ-002 Parameter MAX_HOLD, default 64, SHALL set the maximum number of consecutive granted cycles before forced release under contention.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1  requester n holds high for its whole memory transaction.
REQ-006 addr0, addr1  input  WORD_WIDTH  requester byte address.
REQ-007 wr_en0, wr_en1  input  1  requester write strobe.
REQ-008 wdata0, wdata1  input  WORD_WIDTH  requester write data.
REQ-009 mem_rdata  input  WORD_WIDTH  read data from the shared memory.
REQ-010 gnt0, gnt1  output  1  registered grant, one-hot or zero.
REQ-011 mem_addr, mem_wdata  output  WORD_WIDTH  muxed address and data to memory.
REQ-012 mem_wr_en  output  1  muxed write strobe to memory.
REQ-013 rdata  output  WORD_WIDTH  mem_rdata passed through unchanged to both requesters.
REQ-014 timeout  output  1  one-cycle pulse on forced release.
REQ-015 viol  output  1  one-cycle registered pulse when a non-granted requester asserts its write strobe.

Function
REQ-016 States SHALL be IDLE, OWN0, OWN1, GAP; gnt0 is high only in OWN0, gnt1 only in OWN1.
REQ-017 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the requester not recorded in last_served; neither -> IDLE.
REQ-018 last_served SHALL update to the owner on every entry to OWN0/OWN1.
REQ-019 Grant latency SHALL be exactly one cycle: request sampled high in IDLE gives grant high on the next edge.
REQ-020 OWNn: req n low -> GAP; else hold counter reaches MAX_HOLD-1 with other req high -> GAP and timeout pulse; else stay.
REQ-021 Without contention, OWNn SHALL be held indefinitely; the hold counter saturates at MAX_HOLD-1.
REQ-022 Hold counter SHALL clear on entry to OWN0/OWN1 and increment each cycle in that state.
REQ-023 GAP SHALL last exactly one cycle with both grants low, then go to IDLE.
REQ-024 mem_addr, mem_wdata, mem_wr_en SHALL combinationally follow the granted requester; with no grant they are 0.
REQ-025 A write strobe from the non-granted requester SHALL never reach mem_wr_en, and SHALL raise viol on the following cycle.
REQ-026 In GAP and IDLE no write SHALL reach memory, whatever the requester inputs.
REQ-027 A requester that drops req while owning and raises it again SHALL wait at least the GAP and IDLE cycles.

Reset
REQ-028 nreset low SHALL immediately force state IDLE, gnt0=gnt1=0, timeout=0, viol=0, hold counter 0, last_served=1 so req0 wins the first tie.
REQ-029 Reset asserted mid-transaction SHALL drop the grant and mem_wr_en asynchronously, without waiting for a clock edge.
REQ-030 After reset release, the first arbitration decision SHALL be taken on the first rising edge with nreset high.

Verification
REQ-031 Reset, then req0=req1=1 on the same edge -> gnt0=1 after one cycle; drop req0 -> GAP, IDLE, then gnt1=1.
REQ-032 req1 alone, wr_en1=1, addr1=16'h68A, wdata1=16'h0005 -> mem_wr_en=1, mem_addr=16'h68A, mem_wdata=16'h0005 while gnt1=1.
REQ-033 MAX_HOLD=4, req0 held, req1 raised -> gnt0 high 4 cycles, timeout pulse, 1 GAP cycle, then gnt1=1.
REQ-034 gnt0=1 while wr_en1=1 -> mem_wr_en follows wr_en0 only, viol=1 one cycle later.
REQ-035 nreset pulsed low during OWN1 with wr_en1=1 -> gnt1 and mem_wr_en fall without a clock edge; tie after release goes to req0.
REQ-036 req0 alone held 200 cycles, MAX_HOLD=64 -> gnt0 stays high, timeout never pulses.
